// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU micro-sequencer: FSM state encoding and the
// layout of the 13-bit program ROM word.
package alu_seq_pkg;

  localparam int INSTR_W  = 13;
  localparam int HALT_BIT = 12;
  localparam int F_MSB    = 11;
  localparam int F_LSB    = 8;
  localparam int A_MSB    = 7;
  localparam int A_LSB    = 4;
  localparam int B_MSB    = 3;
  localparam int B_LSB    = 0;
  // Only the executable fields are kept in the instruction register.
  localparam int OP_W     = F_MSB + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_OPER    = 3'd3,
    S_CAPTURE = 3'd4,
    S_PAUSE   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Micro-sequencer: fetches ROM words, drives the ALU operand addresses and
// function code, waits out the operand-memory latency and captures the result.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               step_mode,
  input  logic               step,
  output logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [3:0]         alu_f,
  input  logic [3:0]         alu_r,
  input  logic               alu_d1,
  output logic [3:0]         result,
  output logic               flag,
  output logic               sticky_ovf,
  output logic               result_valid,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc
);

  localparam int               CNT_W   = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT     = CNT_W'(MEM_LAT);
  localparam logic [PC_W-1:0]  PC_LAST = '1;

  state_t           state;
  state_t           state_nxt;
  logic [OP_W-1:0]  instr;
  logic [CNT_W-1:0] cnt;
  logic             launch;
  logic             advance;
  logic             capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nxt = S_FETCH;
        S_FETCH:   state_nxt = S_DECODE;
        S_DECODE:  state_nxt = prog_data[HALT_BIT] ? S_DONE : S_OPER;
        S_OPER:    if (cnt == CNT_W'(1)) state_nxt = S_CAPTURE;
        S_CAPTURE: begin
          // The last ROM slot acts as an implicit halt so pc never wraps.
          if (pc == PC_LAST) state_nxt = S_DONE;
          else if (step_mode) state_nxt = S_PAUSE;
          else state_nxt = S_FETCH;
        end
        S_PAUSE:   if (step || !step_mode) state_nxt = S_FETCH;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  assign launch  = (state == S_IDLE) && (state_nxt == S_FETCH);
  assign advance = ((state == S_CAPTURE) || (state == S_PAUSE)) && (state_nxt == S_FETCH);
  assign capture = (state == S_CAPTURE) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= '0;
      instr        <= '0;
      cnt          <= '0;
      result       <= '0;
      flag         <= 1'b0;
      sticky_ovf   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= capture;
      if (launch) begin
        pc         <= '0;
        sticky_ovf <= 1'b0;
      end else if (advance) begin
        pc <= pc + PC_W'(1);
      end
      if ((state == S_DECODE) && !abort) begin
        instr <= prog_data[OP_W-1:0];
        cnt   <= LAT;
      end else if (state == S_OPER) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        result     <= alu_r;
        flag       <= alu_d1;
        sticky_ovf <= sticky_ovf | alu_d1;
      end
    end
  end

  assign prog_addr = pc;
  assign alu_f     = instr[F_MSB:F_LSB];
  assign alu_a     = instr[A_MSB:A_LSB];
  assign alu_b     = instr[B_MSB:B_LSB];
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: synchronous ROM, 1-cycle operand memory (mem[i]=i)
// and ALU model around the DUT, scored against a program-level reference.
module tb_alu_sequencer;

  localparam int PC_W = 4;
  localparam logic [12:0] HALT = 13'h1000;

  logic            clk, rst, start, abort, step_mode, step;
  logic [PC_W-1:0] prog_addr, pc;
  logic [12:0]     prog_data;
  logic [3:0]      alu_a, alu_b, alu_f, alu_r, result;
  logic            alu_d1, flag, sticky_ovf, result_valid, busy, done;

  logic [12:0] rom [16];
  logic [3:0]  mem_a, mem_b;
  logic [28:0] snap;

  int   checks, errors;
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  logic exp_sticky;
  int   rv_cyc[$];
  int   done_n, done_cyc, end_cyc;
  bit   timeout;

  alu_sequencer #(.PC_W(PC_W), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_mode(step_mode),
    .step(step), .prog_addr(prog_addr), .prog_data(prog_data), .alu_a(alu_a),
    .alu_b(alu_b), .alu_f(alu_f), .alu_r(alu_r), .alu_d1(alu_d1), .result(result),
    .flag(flag), .sticky_ovf(sticky_ovf), .result_valid(result_valid), .busy(busy),
    .done(done), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU semantics: 0010 add (d1=carry), 0011 sub (d1=borrow), 0000 and, 0001 or, else xor.
  function automatic logic [4:0] alu_fn(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    case (f)
      4'b0010: s = {1'b0, a} + {1'b0, b};
      4'b0011: s = {(a < b), 4'(a - b)};
      4'b0000: s = {1'b0, a & b};
      4'b0001: s = {1'b0, a | b};
      default: s = {1'b0, a ^ b};
    endcase
    return s;
  endfunction

  function automatic logic [12:0] op(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b);
    return {1'b0, f, a, b};
  endfunction

  always @(posedge clk) begin
    prog_data <= rom[prog_addr];
    mem_a     <= alu_a;
    mem_b     <= alu_b;
  end

  always_comb {alu_d1, alu_r} = alu_fn(alu_f, mem_a, mem_b);

  always_comb snap = {pc, prog_addr, alu_a, alu_b, alu_f, result, flag, sticky_ovf,
                      result_valid, busy, done};

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = HALT;
  endtask

  // Program-level reference: walk the ROM from slot 0 until a halt word or the last slot.
  task automatic build_expected();
    logic [4:0] v;
    exp_q.delete();
    exp_sticky = 1'b0;
    for (int p = 0; p < 16; p++) begin
      if (rom[p][12]) break;
      v = alu_fn(rom[p][11:8], rom[p][7:4], rom[p][3:0]);
      exp_q.push_back(v);
      exp_sticky = exp_sticky | v[4];
    end
  endtask

  // Free-running run; k counts negedges after the edge that samples start.
  task automatic run_program(input int budget);
    obs_q.delete();
    rv_cyc.delete();
    done_n = 0; done_cyc = -1; end_cyc = -1; timeout = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (result_valid) begin obs_q.push_back({flag, result}); rv_cyc.push_back(k); end
      if (done) begin done_n++; if (done_cyc < 0) done_cyc = k; end
      if (!busy) begin end_cyc = k; break; end
    end
    start = 1'b0;
    if (end_cyc < 0) timeout = 1;
  endtask

  task automatic wait_rv(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (result_valid) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; step = 0; step_mode = 0;
    clear_rom();
    repeat (3) @(negedge clk);
    checks++;
    if (snap !== 29'd0) begin errors++; $display("FAIL reset_hold got %h want 0", snap); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (snap !== 29'd0) begin errors++; $display("FAIL reset_idle got %h want 0", snap); end
  endtask

  task automatic test_single_add();
    clear_rom();
    rom[0] = op(4'b0010, 4'd3, 4'd5);
    run_program(40);
    checks++;
    if (timeout !== 0) begin errors++; $display("FAIL add_timeout got %0d want 0", timeout); end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 5'h08) begin
      errors++; $display("FAIL add_result got n=%0d v=%h want n=1 v=08", obs_q.size(), obs_q.size() ? obs_q[0] : 5'h0);
    end
    checks++;
    if (rv_cyc.size() < 1 || rv_cyc[0] != 4) begin
      errors++; $display("FAIL add_rv_cycle got %0d want 4", rv_cyc.size() ? rv_cyc[0] : -1);
    end
    checks++;
    if (done_n != 1 || done_cyc != 6) begin
      errors++; $display("FAIL add_done got n=%0d cyc=%0d want n=1 cyc=6", done_n, done_cyc);
    end
    checks++;
    if (end_cyc != 7) begin errors++; $display("FAIL add_busy_fall got %0d want 7", end_cyc); end
    checks++;
    if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL add_sticky got %b want 0", sticky_ovf); end
  endtask

  task automatic test_two_ops();
    clear_rom();
    rom[0] = op(4'b0011, 4'd2, 4'd5);
    rom[1] = op(4'b0010, 4'd9, 4'd9);
    run_program(40);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 5'h1D || obs_q[1] !== 5'h12) begin
      errors++; $display("FAIL two_ops got n=%0d %h %h want n=2 1d 12", obs_q.size(),
                         obs_q.size() > 0 ? obs_q[0] : 5'h0, obs_q.size() > 1 ? obs_q[1] : 5'h0);
    end
    checks++;
    if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL two_ops_sticky got %b want 1", sticky_ovf); end
  endtask

  task automatic test_step_mode();
    bit ok;
    clear_rom();
    rom[0] = op(4'b0010, 4'd1, 4'd2);
    rom[1] = op(4'b0011, 4'd3, 4'd4);
    rom[2] = op(4'b0100, 4'd5, 4'd6);
    step_mode = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_rv(20, ok);
    checks++;
    if (!ok || {flag, result} !== 5'h03) begin errors++; $display("FAIL step_first got ok=%0d %h want 03", ok, {flag, result}); end
    repeat (4) @(negedge clk);
    checks++;
    if (pc !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL step_park got pc=%0d busy=%b want 0 1", pc, busy); end
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    checks++;
    if (pc !== 4'd1) begin errors++; $display("FAIL step_advance got %0d want 1", pc); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({alu_f, alu_a, alu_b} !== 12'h334) begin errors++; $display("FAIL step_oper got %h want 334", {alu_f, alu_a, alu_b}); end
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    wait_rv(20, ok);
    checks++;
    if (!ok || {flag, result} !== 5'h1F) begin errors++; $display("FAIL step_second got ok=%0d %h want 1f", ok, {flag, result}); end
    repeat (4) @(negedge clk);
    checks++;
    if (pc !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL step_stray got pc=%0d busy=%b want 1 1", pc, busy); end
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    wait_rv(20, ok);
    checks++;
    if (!ok || {flag, result} !== 5'h03 || pc !== 4'd2) begin
      errors++; $display("FAIL step_third got ok=%0d %h pc=%0d want 03 pc=2", ok, {flag, result}, pc);
    end
    step_mode = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    checks++;
    if (!ok || pc !== 4'd3) begin errors++; $display("FAIL step_release got done=%0d pc=%0d want 1 3", ok, pc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_program();
    clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = op(4'($urandom_range(0, 4)), 4'($urandom), 4'($urandom));
    build_expected();
    run_program(120);
    checks++;
    if (timeout !== 0 || obs_q.size() != 16) begin
      errors++; $display("FAIL full_count got n=%0d timeout=%0d want 16 0", obs_q.size(), timeout);
    end else begin
      foreach (obs_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_op%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL full_done got %0d want 1", done_n); end
    repeat (3) @(negedge clk);
    checks++;
    if (pc !== 4'd15 || busy !== 1'b0) begin errors++; $display("FAIL full_pc got pc=%0d busy=%b want 15 0", pc, busy); end
  endtask

  task automatic test_abort();
    bit ok, saw_busy, saw_done;
    clear_rom();
    rom[0] = op(4'b0011, 4'd9, 4'd4);
    rom[1] = op(4'b0010, 4'd7, 4'd8);
    rom[2] = op(4'b0001, 4'd1, 4'd6);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_rv(20, ok);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!ok || pc !== 4'd1 || {alu_f, alu_a, alu_b} !== 12'h278) begin
      errors++; $display("FAIL abort_setup got ok=%0d pc=%0d alu=%h want 1 1 278", ok, pc, {alu_f, alu_a, alu_b});
    end
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy, done); end
    checks++;
    if ({alu_f, alu_a, alu_b} !== 12'h278 || {flag, result} !== 5'h05) begin
      errors++; $display("FAIL abort_hold got alu=%h res=%h want 278 05", {alu_f, alu_a, alu_b}, {flag, result});
    end
    saw_busy = 0; saw_done = 0;
    repeat (6) begin
      @(negedge clk);
      saw_busy |= busy; saw_done |= done;
    end
    checks++;
    if (saw_busy || saw_done) begin errors++; $display("FAIL abort_stay got busy=%0d done=%0d want 0 0", saw_busy, saw_done); end
  endtask

  task automatic test_async_reset();
    clear_rom();
    rom[0] = op(4'b0010, 4'd3, 4'd5);
    rom[1] = op(4'b0011, 4'd2, 4'd5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (snap !== 29'd0) begin errors++; $display("FAIL async_reset got %h want 0", snap); end
    @(negedge clk); rst = 1'b0;
    build_expected();
    run_program(40);
    checks++;
    if (timeout !== 0 || obs_q.size() != exp_q.size() || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL reset_rerun got n=%0d %h want n=%0d %h", obs_q.size(),
                         obs_q.size() ? obs_q[0] : 5'h0, exp_q.size(), exp_q[0]);
    end
    checks++;
    if (sticky_ovf !== exp_sticky) begin errors++; $display("FAIL reset_sticky got %b want %b", sticky_ovf, exp_sticky); end
  endtask

  task automatic test_back_to_back();
    int len;
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(0, 16);
      for (int i = 0; i < 16; i++) begin
        if (i < len) rom[i] = op(4'($urandom_range(0, 5)), 4'($urandom), 4'($urandom));
        else         rom[i] = HALT | 13'($urandom_range(0, 4095));
      end
      build_expected();
      run_program(120);
      checks++;
      if (timeout !== 0 || obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count got n=%0d timeout=%0d want %0d", r, obs_q.size(), timeout, exp_q.size());
      end else begin
        foreach (obs_q[i]) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_op%0d got %h want %h", r, i, obs_q[i], exp_q[i]); end
        end
      end
      checks++;
      if (sticky_ovf !== exp_sticky || done_n != 1) begin
        errors++; $display("FAIL rand%0d_end got sticky=%b done=%0d want %b 1", r, sticky_ovf, done_n, exp_sticky);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_single_add();
    test_two_ops();
    test_step_mode();
    test_full_program();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
